// File: rtl/gray_decoder_monitor_pkg.sv
// Shared types and defaults for the gray-code stream monitor.
package gray_decoder_monitor_pkg;

  localparam int unsigned DefaultWidth = 5;

  // Monitor FSM: no baseline, acquiring lock, locked, one-cycle fault.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAcquire = 2'd1,
    StLocked  = 2'd2,
    StFault   = 2'd3
  } state_e;

endpackage

// File: rtl/gray_decoder_monitor_gray2bin.sv
// Combinational gray-to-binary decoder: each binary bit is the XOR of all
// gray bits at and above its position.
module gray_decoder_monitor_gray2bin
  import gray_decoder_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Reduction XOR of the upper slice avoids a self-referencing prefix chain.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_decoder_monitor.sv
// Gray-coded count stream monitor: decodes each sample, checks +1 steps on
// enabled cycles and holds on disabled cycles, and tracks lock and errors.
module gray_decoder_monitor
  import gray_decoder_monitor_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     gray_in,
  output logic [WIDTH-1:0]     binary_out,
  output logic                 valid_out,
  output logic                 locked,
  output logic                 step_err,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned GoodW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  state_e                 state_q;
  logic [WIDTH-1:0]       bin_cur;
  logic [WIDTH-1:0]       bin_inc;
  logic [WIDTH-1:0]       prev_gray_q;
  logic [WIDTH-1:0]       prev_bin_q;
  logic [GoodW-1:0]       good_cnt_q;
  logic [GoodW-1:0]       good_inc;
  logic [WIDTH-1:0]       binary_out_q;
  logic                   valid_q;
  logic                   step_err_q;
  logic                   err_q;
  logic [ERR_CNT_W-1:0]   err_count_q;
  logic                   step_ok;

  gray_decoder_monitor_gray2bin #(
    .WIDTH (WIDTH)
  ) u_gray2bin (
    .gray_i (gray_in),
    .bin_o  (bin_cur)
  );

  assign bin_inc  = prev_bin_q + WIDTH'(1);
  assign good_inc = good_cnt_q + GoodW'(1);

  // Step check against the previous sample: +1 (with wrap) when enabled, hold otherwise.
  always_comb begin
    step_ok = 1'b0;
    if (enable) begin
      step_ok = (bin_cur == bin_inc);
    end else begin
      step_ok = (gray_in == prev_gray_q);
    end
  end

  // Sample registers, FSM and error counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      prev_gray_q  <= '0;
      prev_bin_q   <= '0;
      good_cnt_q   <= '0;
      binary_out_q <= '0;
      valid_q      <= 1'b0;
      step_err_q   <= 1'b0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
    end else begin
      valid_q     <= enable;
      step_err_q  <= 1'b0;
      // History re-baselines on every sample, good or bad.
      prev_gray_q <= gray_in;
      prev_bin_q  <= bin_cur;
      if (enable) begin
        binary_out_q <= bin_cur;
      end
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q    <= StAcquire;
            good_cnt_q <= '0;
          end
        end
        StAcquire: begin
          if (!step_ok) begin
            good_cnt_q <= '0;
          end else if (enable) begin
            if (32'(good_inc) >= LOCK_COUNT) begin
              state_q    <= StLocked;
              good_cnt_q <= '0;
            end else begin
              good_cnt_q <= good_inc;
            end
          end
        end
        StLocked: begin
          if (!step_ok) begin
            state_q    <= StFault;
            step_err_q <= 1'b1;
            err_q      <= 1'b1;
            if (err_count_q != '1) begin
              err_count_q <= err_count_q + ERR_CNT_W'(1);
            end
          end
        end
        StFault: begin
          state_q    <= StAcquire;
          good_cnt_q <= '0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign binary_out = binary_out_q;
  assign valid_out  = valid_q;
  assign locked     = (state_q == StLocked);
  assign step_err   = step_err_q;
  assign err        = err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_gray_decoder_monitor.sv
// Scoreboard bench for gray_decoder_monitor (WIDTH=5, LOCK_COUNT=2, ERR_CNT_W=2).
module tb_gray_decoder_monitor;

  localparam int W  = 5;
  localparam int LC = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [W-1:0]  gray_in;
  logic [W-1:0]  binary_out;
  logic          valid_out;
  logic          locked;
  logic          step_err;
  logic          err;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  gray_decoder_monitor #(
    .WIDTH      (W),
    .LOCK_COUNT (LC),
    .ERR_CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .gray_in    (gray_in),
    .binary_out (binary_out),
    .valid_out  (valid_out),
    .locked     (locked),
    .step_err   (step_err),
    .err        (err),
    .err_count  (err_count)
  );

  typedef struct packed {
    logic          v;
    logic [W-1:0]  bin;
    logic          lk;
    logic          se;
    logic          er;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic chk_rst = 1'b0;
  logic done    = 1'b0;

  function automatic logic [W-1:0] to_gray(input int b);
    logic [W-1:0] bb;
    bb = W'(b);
    return bb ^ (bb >> 1);
  endfunction

  // Apply one cycle of stimulus; the expectation is queued at the sampling edge.
  task automatic drive(input logic en, input logic [W-1:0] gr, input logic push,
                       input exp_t e);
    enable  = en;
    gray_in = gr;
    @(posedge clk);
    if (push) q.push_back(e);
    #1;
  endtask

  // Enabled sample of binary value b with the hand-derived resulting outputs.
  task automatic en_step(input int b, input logic lk, input logic se, input logic er,
                         input int cnt);
    exp_t e;
    e.v   = 1'b1;
    e.bin = W'(b);
    e.lk  = lk;
    e.se  = se;
    e.er  = er;
    e.cnt = CW'(cnt);
    drive(1'b1, to_gray(b), 1'b1, e);
  endtask

  task automatic idle(input logic [W-1:0] gr);
    exp_t e;
    e = '0;
    drive(1'b0, gr, 1'b0, e);
  endtask

  task automatic do_reset(input logic en, input logic [W-1:0] gr);
    enable  = en;
    gray_in = gr;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    chk_rst = 1'b1;
    @(posedge clk);
    #1;
    chk_rst = 1'b0;
    reset   = 1'b0;
  endtask

  // Monitor: checks reset state on request, otherwise pops on any DUT output.
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clk);
      act = {valid_out, binary_out, locked, step_err, err, err_count};
      if (chk_rst) begin
        total++;
        if (act !== '0) begin
          bad++;
          $display("FAIL reset_state: got v=%0b bin=%0d lk=%0b se=%0b err=%0b cnt=%0d, want all 0",
                   valid_out, binary_out, locked, step_err, err, err_count);
        end
      end else if (q.size() > 0 || valid_out || step_err) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output @%0t: got v=%0b bin=%0d se=%0b, want none",
                   $time, valid_out, binary_out, step_err);
        end else begin
          e = q.pop_front();
          if (act !== e) begin
            bad++;
            $display("FAIL output @%0t: got v=%0b bin=%0d lk=%0b se=%0b err=%0b cnt=%0d, want v=%0b bin=%0d lk=%0b se=%0b err=%0b cnt=%0d",
                     $time, valid_out, binary_out, locked, step_err, err, err_count,
                     e.v, e.bin, e.lk, e.se, e.er, e.cnt);
          end
        end
      end
      if (done) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    exp_t e;
    reset   = 1'b1;
    enable  = 1'b0;
    gray_in = '0;
    do_reset(1'b0, '0);

    // Disabled samples in IDLE are ignored.
    idle(5'b10101);
    idle(5'b00100);

    // Acquire: 0,1,2,3; lock appears with the third output.
    en_step(0, 1'b0, 1'b0, 1'b0, 0);
    en_step(1, 1'b0, 1'b0, 1'b0, 0);
    en_step(2, 1'b1, 1'b0, 1'b0, 0);
    en_step(3, 1'b1, 1'b0, 1'b0, 0);
    // Count through the top and wrap 31 -> 0.
    for (int b = 4; b < 32; b++) en_step(b, 1'b1, 1'b0, 1'b0, 0);
    for (int b = 0; b < 5; b++) en_step(b, 1'b1, 1'b0, 1'b0, 0);

    // Hold at 4 for three cycles, then a change while disabled.
    for (int i = 0; i < 3; i++) idle(5'b00110);
    e.v = 1'b0; e.bin = 5'd4; e.lk = 1'b0; e.se = 1'b1; e.er = 1'b1; e.cnt = 2'd1;
    drive(1'b0, 5'b00111, 1'b1, e);

    // Re-lock after the fault cycle.
    en_step(6, 1'b0, 1'b0, 1'b1, 1);
    en_step(7, 1'b0, 1'b0, 1'b1, 1);
    en_step(8, 1'b1, 1'b0, 1'b1, 1);

    // Jump while locked; a bad step during ACQUIRE is neither flagged nor counted.
    en_step(10, 1'b0, 1'b1, 1'b1, 2);
    en_step(11, 1'b0, 1'b0, 1'b1, 2);
    en_step(15, 1'b0, 1'b0, 1'b1, 2);
    en_step(16, 1'b0, 1'b0, 1'b1, 2);
    en_step(17, 1'b1, 1'b0, 1'b1, 2);

    en_step(20, 1'b0, 1'b1, 1'b1, 3);
    en_step(21, 1'b0, 1'b0, 1'b1, 3);
    en_step(22, 1'b0, 1'b0, 1'b1, 3);
    en_step(23, 1'b1, 1'b0, 1'b1, 3);

    // Fourth violation: counter stays saturated.
    en_step(0, 1'b0, 1'b1, 1'b1, 3);
    en_step(1, 1'b0, 1'b0, 1'b1, 3);
    en_step(2, 1'b0, 1'b0, 1'b1, 3);
    en_step(3, 1'b1, 1'b0, 1'b1, 3);

    // Reset while locked with err set; history is discarded.
    do_reset(1'b1, to_gray(9));
    en_step(12, 1'b0, 1'b0, 1'b0, 0);
    en_step(13, 1'b0, 1'b0, 1'b0, 0);
    en_step(14, 1'b1, 1'b0, 1'b0, 0);
    idle(to_gray(14));
    idle(to_gray(14));
    done = 1'b1;
  end

endmodule
